// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the 4x8 register file and its
// dump/load access initiator.
package regfile_pkg;

  localparam int NREGS = 4;
  localparam int RF_AW = 2;
  localparam int RF_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    DUMP_FETCH,
    DUMP_SEND,
    LOAD,
    DONE
  } rdl_state_t;

endpackage

// File: rtl/regfile.sv
// 4x8 register file: one synchronous write port, one combinational read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::RF_AW,
  parameter int DW    = regfile_pkg::RF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wen,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] dataIn,
  input  logic [AW-1:0] r_addr,
  output logic [DW-1:0] dataOut
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wen) begin
      mem_q[w_addr] <= dataIn;
    end
  end

  assign dataOut = mem_q[r_addr];

endmodule

// File: rtl/reg_dump_loader.sv
// Host-side access initiator: DUMP streams every register out, LOAD writes
// NREGS incoming bytes to registers 0..NREGS-1. While busy it owns the rf ports.
module reg_dump_loader
  import regfile_pkg::*;
#(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::RF_AW,
  parameter int DW    = regfile_pkg::RF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic          cmd_load,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          rf_wen,
  output logic [AW-1:0] rf_w_addr,
  output logic [DW-1:0] rf_dataIn,
  output logic [AW-1:0] rf_r_addr,
  input  logic [DW-1:0] rf_dataOut
);

  // Termination is by compare so NREGS == 2**AW never relies on wrap-around.
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rdl_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          idx_d   = '0;
          state_d = cmd_load ? LOAD : DUMP_FETCH;
        end
      end
      DUMP_FETCH: begin
        out_data_d = rf_dataOut;
        state_d    = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = DUMP_FETCH;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + AW'(1);
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DUMP_SEND);
    rf_wen    = (state_q == LOAD) && in_valid;
    rf_dataIn = (state_q == LOAD) ? in_data : '0;
  end

  assign out_data  = out_data_q;
  assign rf_w_addr = idx_q;
  assign rf_r_addr = idx_q;

endmodule

// File: tb/tb_reg_dump_loader.sv
// Directed bench: reg_dump_loader driving the real register file.
module tb_reg_dump_loader;
  import regfile_pkg::*;

  logic             clk = 1'b0;
  logic             reset, rf_reset;
  logic             cmd_valid, cmd_load, cmd_ready, busy, done;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [RF_DW-1:0] in_data, out_data;
  logic             rf_wen;
  logic [RF_AW-1:0] rf_w_addr, rf_r_addr;
  logic [RF_DW-1:0] rf_dataIn, rf_dataOut;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_regs [4];
  logic [7:0] ld_data  [4];

  always #5 clk = ~clk;

  reg_dump_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_load(cmd_load), .cmd_ready(cmd_ready),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rf_wen(rf_wen), .rf_w_addr(rf_w_addr), .rf_dataIn(rf_dataIn),
    .rf_r_addr(rf_r_addr), .rf_dataOut(rf_dataOut)
  );

  regfile u_rf (
    .clk(clk), .reset(rf_reset),
    .wen(rf_wen), .w_addr(rf_w_addr), .dataIn(rf_dataIn),
    .r_addr(rf_r_addr), .dataOut(rf_dataOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", tag, i), u_rf.mem_q[i], exp_regs[i]);
  endtask

  // Gap mode inserts one in_valid-low cycle before every byte (8 LOAD cycles).
  task automatic do_load(input string tag, input bit gaps, input bit poke_cmd);
    int load_cycles = 0;
    next_cycle();
    cmd_valid = 1'b1; cmd_load = 1'b1;
    @(negedge clk); chk({tag, "_cmd_ready"}, cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0; cmd_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in_data = 8'hEE;
        @(negedge clk);
        chk($sformatf("%s_gap%0d_wen", tag, i), rf_wen, 0);
        chk($sformatf("%s_gap%0d_in_ready", tag, i), in_ready, 1);
        load_cycles++;
        next_cycle();
      end
      in_valid = 1'b1; in_data = ld_data[i];
      if (poke_cmd && i == 1) cmd_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_b%0d_wen", tag, i), rf_wen, 1);
      chk($sformatf("%s_b%0d_addr", tag, i), rf_w_addr, i);
      chk($sformatf("%s_b%0d_data", tag, i), rf_dataIn, ld_data[i]);
      chk($sformatf("%s_b%0d_cmd_ready", tag, i), cmd_ready, 0);
      load_cycles++;
      next_cycle();
      cmd_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_wen"}, rf_wen, 0);
    chk({tag, "_done_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_cycles"}, load_cycles, gaps ? 8 : 4);
    next_cycle();
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    for (int i = 0; i < 4; i++) exp_regs[i] = ld_data[i];
    chk_regs(tag);
  endtask

  // stall_idx < 0 disables backpressure.
  task automatic do_dump(input string tag, input int stall_idx, input int stall_n);
    next_cycle();
    cmd_valid = 1'b1; cmd_load = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk({tag, "_cmd_ready"}, cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      cmd_valid = 1'b0;
      out_ready = (i == stall_idx) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("%s_f%0d_valid", tag, i), out_valid, 0);
      chk($sformatf("%s_f%0d_raddr", tag, i), rf_r_addr, i);
      chk($sformatf("%s_f%0d_busy", tag, i), busy, 1);
      next_cycle();
      @(negedge clk);
      chk($sformatf("%s_s%0d_valid", tag, i), out_valid, 1);
      chk($sformatf("%s_s%0d_data", tag, i), out_data, exp_regs[i]);
      chk($sformatf("%s_s%0d_wen", tag, i), rf_wen, 0);
      if (i == stall_idx) begin
        for (int k = 1; k < stall_n; k++) begin
          next_cycle();
          @(negedge clk);
          chk($sformatf("%s_hold%0d_valid", tag, k), out_valid, 1);
          chk($sformatf("%s_hold%0d_data", tag, k), out_data, exp_regs[i]);
          chk($sformatf("%s_hold%0d_raddr", tag, k), rf_r_addr, i);
        end
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s_rel_data", tag), out_data, exp_regs[i]);
      end
    end
    next_cycle();
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_valid"}, out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    chk_regs(tag);
  endtask

  initial begin
    reset = 1'b1; rf_reset = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", rf_wen, 0);
    next_cycle();
    reset = 1'b0; rf_reset = 1'b0;

    ld_data[0] = 8'h11; ld_data[1] = 8'h22; ld_data[2] = 8'h33; ld_data[3] = 8'h44;
    do_load("load1", 1'b0, 1'b1);
    do_dump("dump1", -1, 0);
    do_dump("dump_bp", 2, 5);

    ld_data[0] = 8'hA0; ld_data[1] = 8'hA1; ld_data[2] = 8'hA2; ld_data[3] = 8'hA3;
    do_load("load_gap", 1'b1, 1'b0);

    // Abort a LOAD after two bytes; the third byte is presented as reset hits.
    next_cycle();
    cmd_valid = 1'b1; cmd_load = 1'b1;
    next_cycle();
    cmd_valid = 1'b0; cmd_load = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    next_cycle();
    in_data = 8'h5B;
    next_cycle();
    in_data = 8'h5C;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_wen", rf_wen, 0);
    chk("abort_done", done, 0);
    next_cycle();
    in_valid = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort_post%0d_done", k), done, 0);
      chk($sformatf("abort_post%0d_busy", k), busy, 0);
      next_cycle();
    end
    exp_regs[0] = 8'h5A; exp_regs[1] = 8'h5B; exp_regs[2] = 8'hA2; exp_regs[3] = 8'hA3;
    chk_regs("abort");
    do_dump("dump_abort", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_dump_loader.md
Name: reg_dump_loader

Overview:
- Access initiator for the 4x8 register file: drives its write port (wen/w_addr/dataIn) and one read port (r_addr/dataOut) on behalf of a debug/test host.
- DUMP command streams all registers out, index 0 to NREGS-1, over a valid/ready byte stream.
- LOAD command accepts NREGS bytes from a valid/ready input stream and writes them to registers 0 to NREGS-1.
- Sits between the host interface and the register file. While busy=1 it owns the register file ports; the core must stall.

Parameters:
- NREGS, 4, number of registers walked per command.
- AW, 2, register address width (must satisfy 2**AW >= NREGS).
- DW, 8, data width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_load  input  1  command type: 1 = LOAD, 0 = DUMP; sampled when cmd_valid & cmd_ready.
- cmd_ready  output  1  high only in IDLE.
- busy  output  1  high in every state except IDLE; core stall / port ownership.
- done  output  1  one-cycle pulse when a command completes.
- in_valid  input  1  LOAD data valid.
- in_data  input  DW  LOAD data byte.
- in_ready  output  1  high only in LOAD.
- out_valid  output  1  DUMP data valid.
- out_data  output  DW  DUMP data byte (registered).
- out_ready  input  1  DUMP consumer ready.
- rf_wen  output  1  register file write enable.
- rf_w_addr  output  AW  register file write address.
- rf_dataIn  output  DW  register file write data.
- rf_r_addr  output  AW  register file read address.
- rf_dataOut  input  DW  register file read data (combinational read of rf_r_addr).

Behaviour:
- States: IDLE, DUMP_FETCH, DUMP_SEND, LOAD, DONE. Index counter idx (AW bits).
- Reset (async, any state): state=IDLE, idx=0, out_data=0. All outputs 0 except cmd_ready=1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: idx<=0, then cmd_load ? LOAD : DUMP_FETCH.
  - cmd_valid low: stay in IDLE.
- DUMP_FETCH (1 cycle):
  - rf_r_addr=idx.
  - out_data<=rf_dataOut at clock edge, then DUMP_SEND.
- DUMP_SEND:
  - out_valid=1; out_data held stable until the handshake.
  - On out_ready: if idx==NREGS-1 go to DONE, else idx<=idx+1 and go to DUMP_FETCH.
  - Latency: first out_valid 2 cycles after the command handshake. Minimum 2 cycles per byte.
- rf_r_addr equals idx in all states (don't-care outside DUMP_FETCH). Driving idx avoids an extra mux.
- LOAD:
  - in_ready=1.
  - rf_wen = in_valid (combinational); rf_w_addr=idx; rf_dataIn=in_data.
  - On in_valid: if idx==NREGS-1 go to DONE, else idx<=idx+1. One byte per cycle sustained.
- DONE: done=1 for one cycle, idx<=0, then IDLE. cmd_ready=0 in DONE, so back-to-back commands are separated by at least 1 cycle.
- rf_wen is never asserted outside LOAD. No register is written during DUMP.
- Wrap: idx never exceeds NREGS-1. For NREGS=2**AW, termination is by compare, not overflow.
- Stalls:
  - in_valid low in LOAD: no write, idx held.
  - out_ready low in DUMP_SEND: out_valid and out_data held indefinitely.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset mid-operation: command aborted immediately. Registers already written keep their values (no rollback). A partially sent dump is discarded; no done pulse.

Decomposition:
- Shared package (regfile_pkg):
  - constants NREGS=4, RF_AW=2, RF_DW=8.
  - enum typedef rdl_state_t {IDLE, DUMP_FETCH, DUMP_SEND, LOAD, DONE}.
- Single module; the FSM plus idx counter is small. No sub-module.
- Bench instantiates the real register file behind the rf_* ports.

Test Plan:
- LOAD: cmd_load=1, stream bytes 0x11,0x22,0x33,0x44 with in_valid held high -> rf_wen high 4 consecutive cycles at addr 0..3. Register file holds 11/22/33/44; done pulses 1 cycle after the last write.
- DUMP after load, out_ready=1 -> out_data sequence 0x11,0x22,0x33,0x44. First out_valid 2 cycles after the command; bytes spaced 2 cycles apart; done after the 4th byte; rf_wen stays 0.
- Backpressure: DUMP with out_ready low 5 cycles on byte 2 -> out_valid=1 and out_data=0x33 held for 5 cycles. No duplicate or skipped bytes; rf_r_addr does not advance.
- Input gaps: LOAD 0xA0,0xA1,0xA2,0xA3 with in_valid low every other cycle -> exactly 4 writes, no write on idle cycles, correct addresses. Completion takes 8 cycles.
- Reset mid-LOAD: assert reset after 2 bytes (0x5A,0x5B) -> immediate IDLE, busy=0, no done pulse. Regs 0/1 = 5A/5B, regs 2/3 unchanged. A following DUMP reports those values.
- Command while busy: pulse cmd_valid with cmd_load=0 during LOAD -> ignored, LOAD completes normally. cmd_ready=1 again the cycle after done.
